// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter : round-robin burst arbiter for the async FIFO write port
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                  clock_w,
   input  logic                  reset_w,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*DW-1:0] req_data,
   input  logic [NUM_REQ-1:0]    req_last,
   output logic [NUM_REQ-1:0]    ack,
   output logic [NUM_REQ-1:0]    grant,
   output logic                  push,
   output logic [DW-1:0]         data_in,
   input  logic                  full,
   output logic                  busy,
   output logic [15:0]           stall_cnt
);

   localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BCW = 5;
   localparam logic [BCW-1:0]     LAST_BEAT = BCW'(MAX_BURST - 1);
   localparam logic [IW-1:0]      LAST_IDX  = IW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t             state, state_n;
   logic [IW-1:0]      owner, owner_n;
   logic [IW-1:0]      rr_ptr, rr_ptr_n;
   logic [BCW-1:0]     burst_cnt, burst_cnt_n;
   logic [NUM_REQ-1:0] grant_n;
   logic [15:0]        stall_cnt_n;

   logic               pick_valid;
   logic [IW-1:0]      pick;
   logic               owner_req;
   logic               stall;
   logic               exit_burst;

   // First requester at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      pick_valid = 1'b0;
      pick       = rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         logic [IW-1:0] idx;
         idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
         if (!pick_valid && req[idx]) begin
            pick_valid = 1'b1;
            pick       = idx;
         end
      end
   end

   always_comb begin
      owner_req  = (state == BURST) && req[owner];
      push       = owner_req && !full;
      stall      = owner_req && full;
      data_in    = push ? req_data[int'(owner)*DW +: DW] : '0;
      ack        = push ? grant : '0;
      busy       = (state != IDLE);
      exit_burst = (push && (req_last[owner] || (burst_cnt == LAST_BEAT)))
                   || ((state == BURST) && !req[owner]);

      state_n     = state;
      owner_n     = owner;
      rr_ptr_n    = rr_ptr;
      burst_cnt_n = burst_cnt;
      grant_n     = grant;
      stall_cnt_n = stall_cnt;

      if (stall && (stall_cnt != 16'hFFFF)) begin
         stall_cnt_n = stall_cnt + 16'd1;
      end

      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_n     = BURST;
               owner_n     = pick;
               grant_n     = ONE_HOT0 << pick;
               burst_cnt_n = '0;
            end
         end
         BURST: begin
            if (push) begin
               burst_cnt_n = burst_cnt + BCW'(1);
            end
            if (exit_burst) begin
               state_n  = IDLE;
               grant_n  = '0;
               rr_ptr_n = (owner == LAST_IDX) ? '0 : owner + IW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_ff @(posedge clock_w or negedge reset_w) begin
      if (!reset_w) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         grant     <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         rr_ptr    <= rr_ptr_n;
         burst_cnt <= burst_cnt_n;
         grant     <= grant_n;
         stall_cnt <= stall_cnt_n;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// tb_fifo_wr_arbiter : directed self-checking bench for fifo_wr_arbiter
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

   logic        clock_w;
   logic        reset_w;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  ack;
   logic [3:0]  grant;
   logic        push;
   logic [7:0]  data_in;
   logic        full;
   logic        busy;
   logic [15:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   fifo_wr_arbiter #(
      .NUM_REQ   (4),
      .DW        (8),
      .MAX_BURST (4)
   ) dut (
      .clock_w   (clock_w),
      .reset_w   (reset_w),
      .req       (req),
      .req_data  (req_data),
      .req_last  (req_last),
      .ack       (ack),
      .grant     (grant),
      .push      (push),
      .data_in   (data_in),
      .full      (full),
      .busy      (busy),
      .stall_cnt (stall_cnt)
   );

   initial clock_w = 1'b0;
   always #5 clock_w = ~clock_w;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      logic [3:0] eg;
      int         viol;

      reset_w  = 1'b0;
      req      = '0;
      req_data = '0;
      req_last = '0;
      full     = 1'b0;
      repeat (2) @(posedge clock_w);
      #2;
      check("rst_grant", 32'(grant), 0);
      check("rst_push", 32'(push), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ack", 32'(ack), 0);
      check("rst_data", 32'(data_in), 0);
      check("rst_stall", 32'(stall_cnt), 0);
      reset_w = 1'b1;

      // Single requester: two max-length bursts separated by a bubble
      @(posedge clock_w); #1;
      req = 4'b0001;
      req_data[7:0] = 8'hA0;
      #1;
      check("t2_bubble_push", 32'(push), 0);
      check("t2_bubble_grant", 32'(grant), 0);
      for (int b = 0; b < 2; b++) begin
         for (int w = 0; w < 4; w++) begin
            @(posedge clock_w); #1;
            req_data[7:0] = 8'hA0 + 8'(b*4 + w);
            #1;
            check("t2_grant", 32'(grant), 32'h1);
            check("t2_push", 32'(push), 1);
            check("t2_data", 32'(data_in), 32'(8'hA0 + 8'(b*4 + w)));
            check("t2_ack", 32'(ack), 32'h1);
         end
         @(posedge clock_w); #2;
         check("t2_rot_push", 32'(push), 0);
         check("t2_rot_grant", 32'(grant), 0);
         check("t2_rot_busy", 32'(busy), 0);
      end
      #1;
      req = '0;

      // Async reset mid-burst, then re-arbitration from pointer 0
      @(posedge clock_w); #1;
      req = 4'b0001;
      req_data[7:0] = 8'hB0;
      @(posedge clock_w); #2;
      check("t1_pre_push", 32'(push), 1);
      @(posedge clock_w); #2;
      check("t1_pre_busy", 32'(busy), 1);
      #1;
      reset_w = 1'b0;
      #1;
      check("t1_async_grant", 32'(grant), 0);
      check("t1_async_push", 32'(push), 0);
      check("t1_async_busy", 32'(busy), 0);
      check("t1_async_ack", 32'(ack), 0);
      check("t1_async_data", 32'(data_in), 0);
      #2;
      reset_w = 1'b1;
      req = 4'b0010;
      req_data[15:8] = 8'hB1;
      req_last[1] = 1'b1;
      #1;
      check("t1_idle_push", 32'(push), 0);
      @(posedge clock_w); #2;
      check("t1_grant", 32'(grant), 32'h2);
      check("t1_push", 32'(push), 1);
      check("t1_data", 32'(data_in), 32'hB1);
      @(posedge clock_w); #1;
      req = '0;
      req_last = '0;
      #1;
      check("t1_exit_busy", 32'(busy), 0);

      // All four requesting: strict round-robin
      #1;
      reset_w = 1'b0;
      @(posedge clock_w); #2;
      reset_w = 1'b1;
      req_data = {8'd3, 8'd2, 8'd1, 8'd0};
      req = 4'b1111;
      #1;
      check("t3_first_push", 32'(push), 0);
      for (int b = 0; b < 5; b++) begin
         eg = 4'b0001 << (b % 4);
         for (int w = 0; w < 4; w++) begin
            @(posedge clock_w); #2;
            check("t3_grant", 32'(grant), 32'(eg));
            check("t3_data", 32'(data_in), 32'(b % 4));
            check("t3_ack", 32'(ack), 32'(eg));
         end
         @(posedge clock_w); #2;
         check("t3_bubble_push", 32'(push), 0);
      end
      #1;
      req = '0;

      // Full stalls owner 1 for 5 cycles; same word resumes
      @(posedge clock_w); #1;
      req = 4'b0010;
      req_data[15:8] = 8'h5A;
      @(posedge clock_w); #2;
      check("t4_grant", 32'(grant), 32'h2);
      check("t4_data0", 32'(data_in), 32'h5A);
      @(posedge clock_w); #1;
      req_data[15:8] = 8'h5B;
      full = 1'b1;
      #1;
      check("t4_full_push", 32'(push), 0);
      check("t4_full_ack", 32'(ack), 0);
      check("t4_full_data", 32'(data_in), 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clock_w); #2;
         check("t4_full_push", 32'(push), 0);
         check("t4_full_grant", 32'(grant), 32'h2);
      end
      @(posedge clock_w); #1;
      full = 1'b0;
      req_last[1] = 1'b1;
      #1;
      check("t4_stall_cnt", 32'(stall_cnt), 5);
      check("t4_resume_push", 32'(push), 1);
      check("t4_resume_data", 32'(data_in), 32'h5B);
      check("t4_resume_ack", 32'(ack), 32'h2);
      @(posedge clock_w); #1;
      req = '0;
      req_last = '0;
      #1;
      check("t4_exit_busy", 32'(busy), 0);

      // Producer 2 ends its burst on the second word; pointer moves to 3
      #1;
      req = 4'b0100;
      req_data[23:16] = 8'hC0;
      @(posedge clock_w); #2;
      check("t5_grant", 32'(grant), 32'h4);
      check("t5_data0", 32'(data_in), 32'hC0);
      @(posedge clock_w); #1;
      req_data[23:16] = 8'hC1;
      req_last[2] = 1'b1;
      #1;
      check("t5_data1", 32'(data_in), 32'hC1);
      check("t5_push1", 32'(push), 1);
      @(posedge clock_w); #1;
      req = 4'b0101;
      req_last = '0;
      req_data[7:0] = 8'hD0;
      #1;
      check("t5_idle_push", 32'(push), 0);
      check("t5_idle_grant", 32'(grant), 0);
      @(posedge clock_w); #2;
      check("t5_rr_from3", 32'(grant), 32'h1);
      #1;
      req = '0;
      #1;
      check("t5_withdraw_push", 32'(push), 0);
      @(posedge clock_w); #2;
      check("t5_withdraw_busy", 32'(busy), 0);
      check("t5_stall_hold", 32'(stall_cnt), 5);

      // Long full: stall counter saturates and never wraps
      #1;
      req = 4'b0010;
      req_data[15:8] = 8'h77;
      full = 1'b1;
      viol = 0;
      @(posedge clock_w);
      for (int i = 0; i < 70000; i++) begin
         @(posedge clock_w); #1;
         if (push) viol++;
      end
      check("t6_no_push", 32'(viol), 0);
      check("t6_sat", 32'(stall_cnt), 32'hFFFF);
      check("t6_grant", 32'(grant), 32'h2);
      repeat (3) @(posedge clock_w);
      #1;
      check("t6_sat_hold", 32'(stall_cnt), 32'hFFFF);
      full = 1'b0;
      #1;
      check("t6_resume_push", 32'(push), 1);
      check("t6_resume_data", 32'(data_in), 32'h77);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
